ptp_tsu_sfd: RTL and testbench

PTP_TSU_SFD -- requirements
Module: ptp_tsu_sfd

---
 rtl/ptp_tsu_sfd.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ptp_tsu_sfd.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_tsu_sfd.sv
`default_nettype none
// ============================================================================
//  Module      : ptp_tsu_sfd
//  Description : GMII receive timestamp unit. Detects preamble/SFD, captures
//                the RTC time through a toggle handshake, applies ingress
//                latency compensation and queues one 128-bit record per frame
//                in a first-word-fall-through FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ptp_tsu_sfd #(
    parameter int DEPTH  = 16,
    parameter int ADJ_NS = 0
) (
    input  logic                      gmii_clk,
    input  logic                      rst,
    input  logic                      rtc_timer_clk,
    input  logic [79:0]               rtc_timer_in,
    input  logic                      gmii_ctrl,
    input  logic [7:0]                gmii_data,
    input  logic                      q_rd_en,
    output logic                      q_rd_valid,
    output logic [127:0]              q_rd_data,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic [7:0]                q_ovf_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [32:0]     NS_PER_S = 33'd1_000_000_000;
    localparam logic [32:0]     ADJ      = 33'(ADJ_NS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // gmii domain state
    // ------------------------------------------------------------------
    logic          rx_ctrl;
    logic [7:0]    rx_data;
    state_t        state;
    state_t        state_nxt;
    logic          sfd_evt;
    logic          eof_evt;
    logic [2:0]    pre_cnt;
    logic [15:0]   byte_cnt;
    logic [15:0]   seq;

    logic          req;
    logic          ack_sync1;
    logic          ack_sync2;
    logic          ack_prev;
    logic          ack_edge;
    logic          hs_idle;
    logic          frame_ts_ok;
    logic          ts_got;
    logic [79:0]   ts_raw;

    logic [32:0]   ns_sum;
    logic [31:0]   ns_adj;
    logic [47:0]   sec_adj;
    logic          ts_valid;
    logic [127:0]  rec;
    logic          wr_pend;
    logic [127:0]  wr_rec;

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          wr_ok;

    // ------------------------------------------------------------------
    // rtc domain state
    // ------------------------------------------------------------------
    logic          req_sync1;
    logic          req_sync2;
    logic          req_prev;
    logic          ack;
    logic [79:0]   hold;

    // Register the GMII inputs once; all frame logic uses these copies.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            rx_ctrl <= 1'b0;
            rx_data <= 8'd0;
        end else begin
            rx_ctrl <= gmii_ctrl;
            rx_data <= gmii_data;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame FSM next state plus SFD/EOF event strobes.
    always_comb begin
        state_nxt = state;
        sfd_evt   = 1'b0;
        eof_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ctrl) state_nxt = (rx_data == 8'h55) ? PRE : DROP;
            end
            PRE: begin
                if (!rx_ctrl) begin
                    state_nxt = IDLE;
                end else if (rx_data == 8'h55) begin
                    state_nxt = PRE;
                end else if (rx_data == 8'hD5) begin
                    state_nxt = BODY;
                    sfd_evt   = 1'b1;
                end else begin
                    state_nxt = DROP;
                end
            end
            BODY: begin
                if (!rx_ctrl) begin
                    state_nxt = IDLE;
                    eof_evt   = 1'b1;
                end
            end
            DROP: begin
                if (!rx_ctrl) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Preamble and body byte counters, both saturating; frame sequence number.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= 3'd0;
            byte_cnt <= 16'd0;
            seq      <= 16'd0;
        end else begin
            if (state == IDLE && state_nxt == PRE)
                pre_cnt <= 3'd1;
            else if (state == PRE && state_nxt == PRE && pre_cnt != 3'd7)
                pre_cnt <= pre_cnt + 3'd1;

            if (sfd_evt)
                byte_cnt <= 16'd0;
            else if (state == BODY && rx_ctrl && byte_cnt != 16'hFFFF)
                byte_cnt <= byte_cnt + 16'd1;

            if (eof_evt)
                seq <= seq + 16'd1;
        end
    end

    assign hs_idle  = (ack_sync2 == req);
    assign ack_edge = ack_sync2 ^ ack_prev;

    // Request side of the toggle handshake and timestamp pickup on ack change.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            req         <= 1'b0;
            ack_sync1   <= 1'b0;
            ack_sync2   <= 1'b0;
            ack_prev    <= 1'b0;
            frame_ts_ok <= 1'b0;
            ts_got      <= 1'b0;
            ts_raw      <= 80'd0;
        end else begin
            ack_sync1 <= ack;
            ack_sync2 <= ack_sync1;
            ack_prev  <= ack_sync2;
            if (sfd_evt) begin
                frame_ts_ok <= hs_idle;
                if (hs_idle) req <= ~req;
            end
            if (ack_edge) ts_raw <= hold;
            // A new SFD invalidates any earlier capture, including a late one.
            if (sfd_evt)       ts_got <= 1'b0;
            else if (ack_edge) ts_got <= 1'b1;
        end
    end

    // RTC side: sample the time on each request toggle, then answer with ack.
    always_ff @(posedge rtc_timer_clk or posedge rst) begin
        if (rst) begin
            req_sync1 <= 1'b0;
            req_sync2 <= 1'b0;
            req_prev  <= 1'b0;
            ack       <= 1'b0;
            hold      <= 80'd0;
        end else begin
            req_sync1 <= req;
            req_sync2 <= req_sync1;
            req_prev  <= req_sync2;
            if (req_sync2 ^ req_prev) begin
                hold <= rtc_timer_in;
                ack  <= ~ack;
            end
        end
    end

    // Latency compensation with nanosecond carry into seconds, then record assembly.
    always_comb begin
        ns_sum = {1'b0, ts_raw[31:0]} + ADJ;
        if (ns_sum >= NS_PER_S) begin
            ns_adj  = ns_sum[31:0] - 32'd1_000_000_000;
            sec_adj = ts_raw[79:32] + 48'd1;
        end else begin
            ns_adj  = ns_sum[31:0];
            sec_adj = ts_raw[79:32];
        end
        ts_valid = frame_ts_ok & ts_got;
        rec = {byte_cnt,
               ts_valid ? sec_adj : 48'd0,
               ts_valid ? ns_adj  : 32'd0,
               seq,
               14'd0, (byte_cnt == 16'hFFFF), ts_valid};
    end

    // Hold the finished record for one cycle; the FIFO write follows EOF.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            wr_pend <= 1'b0;
            wr_rec  <= 128'd0;
        end else begin
            wr_pend <= eof_evt;
            if (eof_evt) wr_rec <= rec;
        end
    end

    assign q_rd_valid = (q_count != '0);
    assign pop        = q_rd_en & q_rd_valid;
    assign wr_ok      = wr_pend & ((q_count != FULL_CNT) | pop);
    // Empty FIFO presents zero so stale storage never leaks after reset.
    assign q_rd_data  = q_rd_valid ? mem[rd_ptr] : 128'd0;

    // Record storage; no reset needed since reads are gated by q_rd_valid.
    always_ff @(posedge gmii_clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_rec;
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            q_ovf_cnt <= 8'd0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (wr_pend && !wr_ok && q_ovf_cnt != 8'hFF)
                q_ovf_cnt <= q_ovf_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptp_tsu_sfd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ptp_tsu_sfd
//  Description : Directed self-checking bench for ptp_tsu_sfd. Instance A
//                uses DEPTH=4/ADJ_NS=0, instance B uses DEPTH=16/ADJ_NS=200;
//                both see the same GMII stream and RTC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ptp_tsu_sfd;

    logic          gmii_clk      = 1'b0;
    logic          rtc_timer_clk = 1'b0;
    logic          rst           = 1'b1;
    int            rtc_half      = 3;
    logic [79:0]   rtc_timer_in  = 80'd0;
    logic          gmii_ctrl     = 1'b0;
    logic [7:0]    gmii_data     = 8'd0;
    logic          rd_en_a       = 1'b0;
    logic          rd_en_b       = 1'b0;

    logic          valid_a, valid_b;
    logic [127:0]  data_a, data_b;
    logic [2:0]    count_a;
    logic [4:0]    count_b;
    logic [7:0]    ovf_a, ovf_b;

    int            n_checks = 0;
    int            n_pass   = 0;

    ptp_tsu_sfd #(.DEPTH(4), .ADJ_NS(0)) dut_a (
        .gmii_clk      (gmii_clk),
        .rst           (rst),
        .rtc_timer_clk (rtc_timer_clk),
        .rtc_timer_in  (rtc_timer_in),
        .gmii_ctrl     (gmii_ctrl),
        .gmii_data     (gmii_data),
        .q_rd_en       (rd_en_a),
        .q_rd_valid    (valid_a),
        .q_rd_data     (data_a),
        .q_count       (count_a),
        .q_ovf_cnt     (ovf_a)
    );

    ptp_tsu_sfd #(.DEPTH(16), .ADJ_NS(200)) dut_b (
        .gmii_clk      (gmii_clk),
        .rst           (rst),
        .rtc_timer_clk (rtc_timer_clk),
        .rtc_timer_in  (rtc_timer_in),
        .gmii_ctrl     (gmii_ctrl),
        .gmii_data     (gmii_data),
        .q_rd_en       (rd_en_b),
        .q_rd_valid    (valid_b),
        .q_rd_data     (data_b),
        .q_count       (count_b),
        .q_ovf_cnt     (ovf_b)
    );

    always #4 gmii_clk = ~gmii_clk;

    initial forever #(rtc_half) rtc_timer_clk = ~rtc_timer_clk;

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rec(input logic [15:0] len, input logic [47:0] s,
                                         input logic [31:0] ns, input logic [15:0] sq,
                                         input logic [15:0] flags);
        return {len, s, ns, sq, flags};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1ns after a rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge gmii_clk);
        #1;
    endtask

    task automatic put(input logic c, input logic [7:0] d);
        gmii_ctrl = c;
        gmii_data = d;
        tick();
    endtask

    // Ends one cycle after the raw ctrl fall is sampled (registered ctrl low).
    task automatic send_to_eof(input int npre, input int nbody);
        for (int i = 0; i < npre; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < nbody; i++) put(1'b1, 8'(i));
        put(1'b0, 8'h00);
    endtask

    task automatic pop_both();
        rd_en_a = 1'b1;
        rd_en_b = 1'b1;
        tick();
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, valid_a, 1'b0);
        check({tag, "_count"}, count_a, 3'd0);
        check({tag, "_ovf"},   ovf_a,   8'd0);
        check({tag, "_data"},  data_a,  128'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) tick();
        check_zero_outputs("rst");
        rst = 1'b0;
        repeat (2) tick();

        // ---------------- bad preamble ----------------
        put(1'b1, 8'h55);
        put(1'b1, 8'h55);
        put(1'b1, 8'h5D);
        for (int i = 0; i < 8; i++) put(1'b1, 8'(i + 16));
        put(1'b0, 8'h00);
        repeat (4) tick();
        check("badpre_count", count_a, 3'd0);
        check("badpre_valid", valid_a, 1'b0);

        // ---------------- basic frame ----------------
        rtc_timer_in = {48'd5, 32'd100};
        send_to_eof(7, 64);
        check("lat_ctrl_r_fall", valid_a, 1'b0);
        tick();
        check("lat_plus1", valid_a, 1'b0);
        tick();
        check("lat_plus2", valid_a, 1'b1);
        check("basic_count", count_a, 3'd1);
        check("basic_rec", data_a, rec(16'd64, 48'd5, 32'd100, 16'd0, 16'h0001));
        check("basic_rec_adj200", data_b, rec(16'd64, 48'd5, 32'd300, 16'd0, 16'h0001));
        pop_both();
        check("basic_popped", count_a, 3'd0);
        repeat (4) tick();

        // ---------------- ns rollover ----------------
        rtc_timer_in = {48'hFFFF_FFFF_FFFF, 32'd999_999_900};
        send_to_eof(7, 16);
        repeat (2) tick();
        check("roll_rec", data_b, rec(16'd16, 48'd0, 32'd100, 16'd1, 16'h0001));
        check("noroll_rec", data_a, rec(16'd16, 48'hFFFF_FFFF_FFFF, 32'd999_999_900, 16'd1, 16'h0001));
        pop_both();
        repeat (4) tick();

        // ---------------- overflow ----------------
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rtc_timer_in = {48'd1, 32'd0};
        for (int f = 0; f < 6; f++) begin
            send_to_eof(7, 16);
            repeat (4) tick();
        end
        check("ovf_count", count_a, 3'd4);
        check("ovf_drops", ovf_a, 8'd2);
        for (int k = 0; k < 4; k++) begin
            check("ovf_seq", data_a[31:16], 16'(k));
            rd_en_a = 1'b1;
            tick();
            rd_en_a = 1'b0;
        end
        check("drained_valid", valid_a, 1'b0);
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        check("empty_pop_ignored", count_a, 3'd0);
        check("empty_pop_ovf", ovf_a, 8'd2);

        // ---------------- full with simultaneous pop and write ----------------
        for (int f = 0; f < 4; f++) begin
            send_to_eof(7, 16);
            repeat (4) tick();
        end
        check("refill_count", count_a, 3'd4);
        check("refill_head", data_a[31:16], 16'd6);
        send_to_eof(7, 16);
        tick();
        rd_en_a = 1'b1;
        tick();
        rd_en_a = 1'b0;
        check("full_popwr_count", count_a, 3'd4);
        check("full_popwr_ovf", ovf_a, 8'd2);
        check("full_popwr_head", data_a[31:16], 16'd7);
        repeat (4) tick();
        send_to_eof(7, 16);
        repeat (2) tick();
        check("full_drop_ovf", ovf_a, 8'd3);
        check("full_drop_count", count_a, 3'd4);

        // ---------------- short frame with slow RTC ----------------
        rst = 1'b1;
        repeat (2) tick();
        check_zero_outputs("rst2");
        rst = 1'b0;
        tick();
        rtc_half = 200;
        repeat (4) tick();
        rtc_timer_in = {48'd9, 32'd9};
        send_to_eof(7, 2);
        repeat (2) tick();
        check("short_rec", data_a, rec(16'd2, 48'd0, 32'd0, 16'd0, 16'h0000));
        repeat (250) tick();
        check("late_ack_count", count_a, 3'd1);
        check("late_ack_rec", data_a, rec(16'd2, 48'd0, 32'd0, 16'd0, 16'h0000));

        // ---------------- reset mid-frame ----------------
        rtc_half = 3;
        repeat (60) tick();
        for (int i = 0; i < 7; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < 5; i++) put(1'b1, 8'(i));
        rst = 1'b1;
        gmii_ctrl = 1'b0;
        gmii_data = 8'h00;
        repeat (2) tick();
        check_zero_outputs("midrst");
        rst = 1'b0;
        repeat (2) tick();
        rtc_timer_in = {48'd7, 32'd42};
        send_to_eof(7, 16);
        repeat (2) tick();
        check("post_rst_rec", data_a, rec(16'd16, 48'd7, 32'd42, 16'd0, 16'h0001));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
